// File: rtl/calc_pkg.sv
// Shared key codes, display glyphs, state/op encodings and helpers for the keypad calculator core.
package calc_pkg;

    localparam logic [4:0] KEY_ADD = 5'h0A;
    localparam logic [4:0] KEY_SUB = 5'h0B;
    localparam logic [4:0] KEY_MUL = 5'h0C;
    localparam logic [4:0] KEY_DIV = 5'h0D;
    localparam logic [4:0] KEY_CLR = 5'h0E;
    localparam logic [4:0] KEY_EQ  = 5'h0F;

    localparam logic [3:0] GLYPH_NEG = 4'hF;
    localparam logic [3:0] GLYPH_E   = 4'hE;
    localparam logic [3:0] GLYPH_D   = 4'hD;

    // Wide enough to hold 10^DIGITS next to a doubled operand width for DIGITS up to 32.
    localparam int POW_BITS = 256;

    typedef enum logic [2:0] {
        ST_ENTRY,
        ST_COMPUTE,
        ST_CONVERT,
        ST_FORMAT,
        ST_ERROR
    } state_t;

    typedef enum logic [2:0] {
        OP_NONE,
        OP_ADD,
        OP_SUB,
        OP_MUL,
        OP_DIV
    } op_t;

    function automatic logic [POW_BITS-1:0] pow10(input int n);
        logic [POW_BITS-1:0] p;
        p = POW_BITS'(1);
        for (int i = 0; i < n; i++) begin
            p = p * POW_BITS'(10);
        end
        return p;
    endfunction

    function automatic op_t keyToOp(input logic [4:0] code);
        op_t o;
        o = OP_NONE;
        case (code)
            KEY_ADD: o = OP_ADD;
            KEY_SUB: o = OP_SUB;
            KEY_MUL: o = OP_MUL;
            KEY_DIV: o = OP_DIV;
            default: o = OP_NONE;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/calc_bin2bcd.sv
// Iterative double-dabble converter: one shift per clock, W clocks from start to final BCD.
module calc_bin2bcd #(
    parameter int DIGITS = 8
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  clr,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bin,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int W  = 4 * DIGITS;
    localparam int CW = $clog2(W + 1);

    logic [W-1:0]   r_bin;
    logic [W-1:0]   r_bcd;
    logic [CW-1:0]  r_cnt;
    logic [W-1:0]   w_adj;
    logic [2*W-1:0] w_step;

    // Add-3 correction on every nibble of 5 or more before the shift.
    always_comb begin
        w_adj = r_bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) begin
                w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    assign w_step = {w_adj, r_bin} << 1;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_bin <= '0;
            r_bcd <= '0;
            r_cnt <= '0;
        end else if (clr) begin
            r_bin <= '0;
            r_bcd <= '0;
            r_cnt <= '0;
        end else if (start) begin
            r_bin <= bin;
            r_bcd <= '0;
            r_cnt <= CW'(W);
        end else if (r_cnt != '0) begin
            r_bcd <= w_step[2*W-1:W];
            r_bin <= w_step[W-1:0];
            r_cnt <= r_cnt - CW'(1);
        end
    end

    // Flags the cycle whose edge performs the final shift, so bcd is complete on the next cycle.
    assign done = (r_cnt == CW'(1));
    assign bcd  = r_bcd;

endmodule

// File: rtl/calc_core_pipe.sv
// Keypad calculator core: BCD entry display, multi-cycle + - * / with overflow and sign handling.
module calc_core_pipe
    import calc_pkg::*;
#(
    parameter int DIGITS = 8
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 key_valid,
    input  logic [4:0]           key_code,
    output logic [4*DIGITS-1:0]  dataout,
    output logic                 busy,
    output logic                 err
);

    localparam int W  = 4 * DIGITS;
    localparam int CW = $clog2(W + 1);
    localparam int NW = $clog2(DIGITS + 1);

    localparam logic [POW_BITS-1:0] POW_FULL = pow10(DIGITS);
    localparam logic [POW_BITS-1:0] POW_SIGN = pow10(DIGITS - 1);
    localparam logic [2*W-1:0]      LIM_POS  = POW_FULL[2*W-1:0];
    localparam logic [2*W-1:0]      LIM_NEG  = POW_SIGN[2*W-1:0];
    localparam logic [W-1:0]        ERR_DISP = {{(W-12){1'b0}}, GLYPH_E, GLYPH_D, GLYPH_D};

    state_t         r_state;
    op_t            r_op;
    logic [W-1:0]   r_entry;
    logic [W-1:0]   r_acc;
    logic [W-1:0]   r_mag;
    logic           r_neg;
    logic [NW-1:0]  r_ndig;
    logic           r_fresh;
    logic [W-1:0]   r_dataout;
    logic           r_busy;
    logic           r_err;
    logic [W-1:0]   r_divRem;
    logic [W-1:0]   r_divQuo;
    logic [CW-1:0]  r_divCnt;

    logic           w_keyClr;
    logic           w_isDigit;
    logic           w_isOp;
    logic [W:0]     w_remShift;
    logic [W:0]     w_remDiff;
    logic           w_borrow;
    logic [W-1:0]   w_remNext;
    logic [W-1:0]   w_quoNext;
    logic [2*W-1:0] w_fullMag;
    logic           w_negNext;
    logic           w_doneNow;
    logic           w_divZero;
    logic           w_overflow;
    logic           w_convStart;
    logic           w_convDone;
    logic [W-1:0]   w_bcd;
    logic [W-1:0]   w_fmt;
    int             w_msd;

    assign w_keyClr  = key_valid && (key_code == KEY_CLR);
    assign w_isDigit = (key_code < 5'h0A);
    assign w_isOp    = (key_code >= KEY_ADD) && (key_code <= KEY_DIV);

    // Restoring divide step; the remainder is always below the divisor so it fits in W bits.
    assign w_remShift = {r_divRem, r_divQuo[W-1]};
    assign w_remDiff  = w_remShift - {1'b0, r_entry};
    assign w_borrow   = w_remDiff[W];
    assign w_remNext  = w_borrow ? w_remShift[W-1:0] : w_remDiff[W-1:0];
    assign w_quoNext  = {r_divQuo[W-2:0], ~w_borrow};

    always_comb begin
        w_fullMag = '0;
        w_negNext = 1'b0;
        w_doneNow = 1'b0;
        unique case (r_op)
            OP_ADD: begin
                w_fullMag = (2*W)'(r_acc) + (2*W)'(r_entry);
                w_doneNow = 1'b1;
            end
            OP_SUB: begin
                if (r_acc >= r_entry) begin
                    w_fullMag = (2*W)'(r_acc - r_entry);
                end else begin
                    w_fullMag = (2*W)'(r_entry - r_acc);
                    w_negNext = 1'b1;
                end
                w_doneNow = 1'b1;
            end
            OP_MUL: begin
                w_fullMag = (2*W)'(r_acc) * (2*W)'(r_entry);
                w_doneNow = 1'b1;
            end
            OP_DIV: begin
                w_fullMag = (2*W)'(w_quoNext);
                w_doneNow = (r_divCnt == CW'(1));
            end
            default: begin
                w_fullMag = (2*W)'(r_entry);
                w_doneNow = 1'b1;
            end
        endcase
    end

    // A negative result needs one spare digit for the sign glyph.
    assign w_divZero   = (r_op == OP_DIV) && (r_entry == '0);
    assign w_overflow  = (w_fullMag >= LIM_POS) || (w_negNext && (w_fullMag >= LIM_NEG));
    assign w_convStart = (r_state == ST_COMPUTE) && w_doneNow && !w_divZero && !w_overflow
                         && !w_keyClr;

    calc_bin2bcd #(
        .DIGITS (DIGITS)
    ) u_bin2bcd (
        .CLK   (CLK),
        .RST_N (RST_N),
        .clr   (w_keyClr),
        .start (w_convStart),
        .bin   (w_fullMag[W-1:0]),
        .done  (w_convDone),
        .bcd   (w_bcd)
    );

    always_comb begin
        w_fmt = w_bcd;
        w_msd = 0;
        for (int i = 0; i < DIGITS; i++) begin
            if (w_bcd[4*i +: 4] != 4'h0) begin
                w_msd = i;
            end
        end
        if (r_neg && (w_msd < DIGITS - 1)) begin
            w_fmt[4*(w_msd+1) +: 4] = GLYPH_NEG;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state   <= ST_ENTRY;
            r_op      <= OP_NONE;
            r_entry   <= '0;
            r_acc     <= '0;
            r_mag     <= '0;
            r_neg     <= 1'b0;
            r_ndig    <= '0;
            r_fresh   <= 1'b0;
            r_dataout <= '0;
            r_busy    <= 1'b0;
            r_err     <= 1'b0;
            r_divRem  <= '0;
            r_divQuo  <= '0;
            r_divCnt  <= '0;
        end else if (w_keyClr) begin
            r_state   <= ST_ENTRY;
            r_op      <= OP_NONE;
            r_entry   <= '0;
            r_acc     <= '0;
            r_mag     <= '0;
            r_neg     <= 1'b0;
            r_ndig    <= '0;
            r_fresh   <= 1'b0;
            r_dataout <= '0;
            r_busy    <= 1'b0;
            r_err     <= 1'b0;
            r_divRem  <= '0;
            r_divQuo  <= '0;
            r_divCnt  <= '0;
        end else begin
            unique case (r_state)
                ST_ENTRY: begin
                    if (key_valid) begin
                        if (w_isDigit) begin
                            if (r_fresh) begin
                                r_dataout <= {{(W-4){1'b0}}, key_code[3:0]};
                                r_entry   <= W'(key_code[3:0]);
                                r_ndig    <= NW'(1);
                                r_fresh   <= 1'b0;
                            end else if (r_ndig < NW'(DIGITS)) begin
                                r_dataout <= {r_dataout[W-5:0], key_code[3:0]};
                                r_entry   <= (r_entry << 3) + (r_entry << 1) + W'(key_code[3:0]);
                                r_ndig    <= r_ndig + NW'(1);
                            end
                        end else if (w_isOp) begin
                            // Right after a result with nothing typed, acc already holds that result.
                            if (!r_fresh) begin
                                r_acc <= r_entry;
                            end
                            r_op      <= keyToOp(key_code);
                            r_entry   <= '0;
                            r_ndig    <= '0;
                            r_dataout <= '0;
                            r_fresh   <= 1'b0;
                        end else if (key_code == KEY_EQ) begin
                            r_state  <= ST_COMPUTE;
                            r_busy   <= 1'b1;
                            r_fresh  <= 1'b0;
                            r_divRem <= '0;
                            r_divQuo <= r_acc;
                            r_divCnt <= CW'(W);
                        end
                    end
                end
                ST_COMPUTE: begin
                    if (w_divZero || (w_doneNow && w_overflow)) begin
                        r_state   <= ST_ERROR;
                        r_dataout <= ERR_DISP;
                        r_err     <= 1'b1;
                        r_busy    <= 1'b0;
                    end else if (w_doneNow) begin
                        r_mag   <= w_fullMag[W-1:0];
                        r_neg   <= w_negNext;
                        r_state <= ST_CONVERT;
                    end else begin
                        r_divRem <= w_remNext;
                        r_divQuo <= w_quoNext;
                        r_divCnt <= r_divCnt - CW'(1);
                    end
                end
                ST_CONVERT: begin
                    if (w_convDone) begin
                        r_state <= ST_FORMAT;
                    end
                end
                ST_FORMAT: begin
                    // Only the magnitude is chained; the sign lives on the display alone.
                    r_dataout <= w_fmt;
                    r_acc     <= r_mag;
                    r_fresh   <= 1'b1;
                    r_op      <= OP_NONE;
                    r_ndig    <= '0;
                    r_busy    <= 1'b0;
                    r_state   <= ST_ENTRY;
                end
                ST_ERROR: begin
                    r_state <= ST_ERROR;
                end
                default: begin
                    r_state <= ST_ENTRY;
                end
            endcase
        end
    end

    assign dataout = r_dataout;
    assign busy    = r_busy;
    assign err     = r_err;

endmodule

// File: tb/tb_calc_core_pipe.sv
// Directed scoreboard bench for calc_core_pipe: key sequences in, expected displays and busy spans checked.
module tb_calc_core_pipe;
    import calc_pkg::*;

    localparam int DIGITS = 8;
    localparam int DW     = 4 * DIGITS;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          errFlag;
        logic [7:0]    cycles;
    } exp_t;

    logic          CLK;
    logic          RST_N;
    logic          key_valid;
    logic [4:0]    key_code;
    logic [DW-1:0] dataout;
    logic          busy;
    logic          err;

    exp_t sbq[$];
    int   compareCount = 0;
    int   failCount    = 0;

    calc_core_pipe #(
        .DIGITS (DIGITS)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .key_valid (key_valid),
        .key_code  (key_code),
        .dataout   (dataout),
        .busy      (busy),
        .err       (err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        compareCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Key is held for exactly one rising edge; returns on the falling edge after acceptance.
    task automatic applyStimulus(input logic [4:0] code);
        @(negedge CLK);
        key_valid = 1'b1;
        key_code  = code;
        @(negedge CLK);
        key_valid = 1'b0;
        key_code  = 5'h00;
    endtask

    task automatic pushExpected(input logic [DW-1:0] data, input logic errFlag,
                                input int cycles);
        exp_t e;
        e.data    = data;
        e.errFlag = errFlag;
        e.cycles  = 8'(cycles);
        sbq.push_back(e);
    endtask

    task automatic waitResult(input string tag);
        exp_t e;
        int   cycles;
        cycles = 0;
        checkOutput({tag, " busy-rise"}, 64'(busy), 64'd1);
        while (busy === 1'b1 && cycles < 200) begin
            @(negedge CLK);
            cycles++;
        end
        e = sbq.pop_front();
        checkOutput({tag, " busy-cycles"}, 64'(cycles), 64'(e.cycles));
        checkOutput({tag, " dataout"}, 64'(dataout), 64'(e.data));
        checkOutput({tag, " err"}, 64'(err), 64'(e.errFlag));
    endtask

    initial begin
        RST_N     = 1'b0;
        key_valid = 1'b0;
        key_code  = 5'h00;
        repeat (3) @(negedge CLK);
        checkOutput("reset dataout", 64'(dataout), 64'd0);
        checkOutput("reset busy", 64'(busy), 64'd0);
        checkOutput("reset err", 64'(err), 64'd0);
        RST_N = 1'b1;

        applyStimulus(5'h01);
        applyStimulus(5'h02);
        checkOutput("entry 12", 64'(dataout), 64'h12);
        applyStimulus(KEY_ADD);
        checkOutput("op clears display", 64'(dataout), 64'h0);
        applyStimulus(5'h03);
        applyStimulus(5'h04);
        pushExpected(32'h0000_0046, 1'b0, 34);
        applyStimulus(KEY_EQ);
        waitResult("12+34");

        applyStimulus(KEY_CLR);
        applyStimulus(5'h05);
        applyStimulus(KEY_SUB);
        applyStimulus(5'h09);
        pushExpected(32'h0000_00F4, 1'b0, 34);
        applyStimulus(KEY_EQ);
        waitResult("5-9");

        applyStimulus(5'h07);
        applyStimulus(KEY_SUB);
        applyStimulus(5'h07);
        pushExpected(32'h0000_0000, 1'b0, 34);
        applyStimulus(KEY_EQ);
        waitResult("7-7");

        applyStimulus(5'h01);
        applyStimulus(5'h00);
        applyStimulus(5'h00);
        applyStimulus(KEY_DIV);
        applyStimulus(5'h07);
        pushExpected(32'h0000_0014, 1'b0, 65);
        applyStimulus(KEY_EQ);
        waitResult("100/7");

        applyStimulus(5'h07);
        applyStimulus(KEY_DIV);
        applyStimulus(5'h00);
        pushExpected(32'h0000_0EDD, 1'b1, 1);
        applyStimulus(KEY_EQ);
        waitResult("7/0");
        applyStimulus(5'h03);
        checkOutput("error ignores digit data", 64'(dataout), 64'h0EDD);
        checkOutput("error ignores digit err", 64'(err), 64'd1);
        applyStimulus(KEY_CLR);
        checkOutput("clear after error data", 64'(dataout), 64'h0);
        checkOutput("clear after error err", 64'(err), 64'd0);

        repeat (8) applyStimulus(5'h09);
        applyStimulus(KEY_MUL);
        applyStimulus(5'h02);
        pushExpected(32'h0000_0EDD, 1'b1, 1);
        applyStimulus(KEY_EQ);
        waitResult("99999999*2");
        applyStimulus(KEY_CLR);

        applyStimulus(5'h01);
        applyStimulus(KEY_SUB);
        applyStimulus(5'h02);
        repeat (7) applyStimulus(5'h00);
        pushExpected(32'h0000_0EDD, 1'b1, 1);
        applyStimulus(KEY_EQ);
        waitResult("1-20000000");
        applyStimulus(KEY_CLR);

        for (int d = 1; d <= 9; d++) begin
            applyStimulus(5'(d));
        end
        checkOutput("nine digits", 64'(dataout), 64'h1234_5678);
        applyStimulus(KEY_CLR);

        applyStimulus(5'h01);
        applyStimulus(5'h02);
        applyStimulus(KEY_ADD);
        applyStimulus(5'h03);
        pushExpected(32'h0000_0015, 1'b0, 34);
        applyStimulus(KEY_EQ);
        waitResult("12+3");
        applyStimulus(KEY_MUL);
        applyStimulus(5'h02);
        pushExpected(32'h0000_0030, 1'b0, 34);
        applyStimulus(KEY_EQ);
        waitResult("chain *2");
        applyStimulus(5'h04);
        checkOutput("fresh entry", 64'(dataout), 64'h4);

        applyStimulus(KEY_CLR);
        applyStimulus(5'h09);
        applyStimulus(5'h09);
        applyStimulus(KEY_DIV);
        applyStimulus(5'h03);
        applyStimulus(KEY_EQ);
        repeat (9) @(negedge CLK);
        checkOutput("divide in flight", 64'(busy), 64'd1);
        applyStimulus(KEY_CLR);
        checkOutput("mid-divide clear busy", 64'(busy), 64'd0);
        checkOutput("mid-divide clear data", 64'(dataout), 64'h0);
        applyStimulus(5'h06);
        checkOutput("digit after clear", 64'(dataout), 64'h6);
        repeat (80) @(negedge CLK);
        checkOutput("aborted divide stays quiet", 64'(dataout), 64'h6);
        checkOutput("aborted divide busy", 64'(busy), 64'd0);

        applyStimulus(KEY_CLR);
        applyStimulus(5'h01);
        applyStimulus(KEY_ADD);
        applyStimulus(5'h01);
        applyStimulus(KEY_EQ);
        repeat (10) @(negedge CLK);
        checkOutput("convert in flight busy", 64'(busy), 64'd1);
        checkOutput("convert in flight data", 64'(dataout), 64'h1);
        #2;
        RST_N = 1'b0;
        #1;
        checkOutput("async reset data", 64'(dataout), 64'h0);
        checkOutput("async reset busy", 64'(busy), 64'd0);
        checkOutput("async reset err", 64'(err), 64'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        repeat (2) @(negedge CLK);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
